// File: rtl/fp_div_pkg.sv
// Shared definitions for the FP divider post stage: rounding modes, special codes,
// FSM encoding, canonical constants and fflags bit positions.
package fp_div_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [2:0] SP_NONE    = 3'b000;
  localparam logic [2:0] SP_QNAN    = 3'b001;
  localparam logic [2:0] SP_INVALID = 3'b010;
  localparam logic [2:0] SP_INF     = 3'b011;
  localparam logic [2:0] SP_DIVZERO = 3'b100;
  localparam logic [2:0] SP_ZERO    = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] CANON_NAN  = 32'h7FC0_0000;
  localparam logic [31:0] MAX_FINITE = 32'h7F7F_FFFF;
  localparam logic [31:0] POS_INF    = 32'h7F80_0000;

  localparam int FF_NX = 0;
  localparam int FF_UF = 1;
  localparam int FF_OF = 2;
  localparam int FF_DZ = 3;
  localparam int FF_NV = 4;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  fflags;
  } fp_res_t;

  // Result for operands resolved before the mantissa divider runs; unknown codes give qNaN.
  function automatic fp_res_t special_result(input logic [2:0] code, input logic sign);
    fp_res_t r;
    r.result = CANON_NAN;
    r.fflags = '0;
    case (code)
      SP_INVALID: r.fflags[FF_NV] = 1'b1;
      SP_INF:     r.result = POS_INF | {sign, 31'b0};
      SP_DIVZERO: begin
        r.result = POS_INF | {sign, 31'b0};
        r.fflags[FF_DZ] = 1'b1;
      end
      SP_ZERO:    r.result = {sign, 31'b0};
      default:    ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fp_round_inc.sv
// Round-increment decision for a truncated significand, shared by the FP post stages.
// Reserved rounding modes fall back to round-to-nearest-even.
module fp_round_inc
  import fp_div_pkg::*;
(
  input  logic       sign,
  input  logic [2:0] rm,
  input  logic       lsb,
  input  logic       rnd,
  input  logic       stk,
  output logic       inc,
  output logic       inexact
);

  always_comb begin
    inexact = rnd | stk;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = inexact & sign;
      RM_RUP:  inc = inexact & ~sign;
      RM_RMM:  inc = rnd;
      default: inc = rnd & (stk | lsb);
    endcase
  end

endmodule

// File: rtl/fp_div_post.sv
// Divider post stage: waits out the mantissa divider, then normalizes, rounds and
// packs a binary32 result with fflags behind a valid/ack handshake.
module fp_div_post
  import fp_div_pkg::*;
#(
  parameter int EXP_W  = 10,
  parameter int MANT_W = 24
) (
  input  logic              in_Clk,
  input  logic              in_Rst,
  input  logic              in_start,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [2:0]        in_rm,
  input  logic [2:0]        in_special,
  input  logic              in_div_stall,
  input  logic [MANT_W-1:0] in_quotient,
  input  logic              in_guard,
  input  logic              in_sticky,
  input  logic              in_ack,
  output logic [31:0]       out_result,
  output logic [4:0]        out_fflags,
  output logic              out_valid,
  output logic              out_busy
);

  // Two extra bits so exp-1 and exp+1 never wrap.
  localparam int EW = EXP_W + 2;

  state_t            state, state_nxt;
  logic              sign_q;
  logic [EXP_W-1:0]  exp_q;
  logic [2:0]        rm_q;
  logic [2:0]        spec_q;
  logic              seen_stall;
  logic [MANT_W-1:0] quo_q;
  logic              grd_q, stk_q;
  logic [31:0]       result_q;
  logic [4:0]        fflags_q;

  logic [EW-1:0]     e_pre, e_post;
  logic [MANT_W-1:0] mant, mant_rnd;
  logic [MANT_W:0]   sum;
  logic              rbit, inc, inexact, to_inf, uflow, oflow;
  fp_res_t           rnd_res;

  fp_round_inc u_round_inc (
    .sign    (sign_q),
    .rm      (rm_q),
    .lsb     (mant[0]),
    .rnd     (rbit),
    .stk     (stk_q),
    .inc     (inc),
    .inexact (inexact)
  );

  // Normalize: a quotient below 1.0 shifts the guard bit in and loses its round bit.
  always_comb begin
    if (quo_q[MANT_W-1]) begin
      mant  = quo_q;
      rbit  = grd_q;
      e_pre = {{2{exp_q[EXP_W-1]}}, exp_q};
    end else begin
      mant  = {quo_q[MANT_W-2:0], grd_q};
      rbit  = 1'b0;
      e_pre = {{2{exp_q[EXP_W-1]}}, exp_q} - EW'(1);
    end
  end

  always_comb begin
    sum = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
    if (sum[MANT_W]) begin
      mant_rnd = {1'b1, {(MANT_W-1){1'b0}}};
      e_post   = e_pre + EW'(1);
    end else begin
      mant_rnd = sum[MANT_W-1:0];
      e_post   = e_pre;
    end
  end

  always_comb begin
    case (rm_q)
      RM_RTZ:  to_inf = 1'b0;
      RM_RDN:  to_inf = sign_q;
      RM_RUP:  to_inf = ~sign_q;
      default: to_inf = 1'b1;
    endcase
    uflow = e_pre[EW-1] | (e_pre == '0);
    oflow = ~e_post[EW-1] & (e_post >= EW'(255));

    rnd_res.result         = {sign_q, e_post[7:0], mant_rnd[MANT_W-2:0]};
    rnd_res.fflags         = '0;
    rnd_res.fflags[FF_NX]  = inexact;
    if (uflow) begin
      rnd_res.result        = {sign_q, 31'b0};
      rnd_res.fflags[FF_UF] = 1'b1;
      rnd_res.fflags[FF_NX] = 1'b1;
    end else if (oflow) begin
      rnd_res.result        = (to_inf ? POS_INF : MAX_FINITE) | {sign_q, 31'b0};
      rnd_res.fflags[FF_OF] = 1'b1;
      rnd_res.fflags[FF_NX] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_start) state_nxt = (in_special != SP_NONE) ? ST_DONE : ST_WAIT;
      ST_WAIT:  if (seen_stall && !in_div_stall) state_nxt = ST_ROUND;
      ST_ROUND: state_nxt = ST_DONE;
      ST_DONE:  if (in_ack) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      state      <= ST_IDLE;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      rm_q       <= '0;
      spec_q     <= '0;
      seen_stall <= 1'b0;
      quo_q      <= '0;
      grd_q      <= 1'b0;
      stk_q      <= 1'b0;
      result_q   <= '0;
      fflags_q   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (in_start) begin
          sign_q     <= in_sign;
          exp_q      <= in_exp;
          rm_q       <= in_rm;
          spec_q     <= in_special;
          seen_stall <= 1'b0;
          if (in_special != SP_NONE)
            {result_q, fflags_q} <= special_result(in_special, in_sign);
        end
        // The divider may need a cycle to raise stall; only its falling edge means done.
        ST_WAIT: begin
          if (in_div_stall) seen_stall <= 1'b1;
          else if (seen_stall) begin
            quo_q <= in_quotient;
            grd_q <= in_guard;
            stk_q <= in_sticky;
          end
        end
        ST_ROUND: {result_q, fflags_q} <= rnd_res;
        default: ;
      endcase
    end
  end

  assign out_result = result_q;
  assign out_fflags = fflags_q;
  assign out_valid  = (state == ST_DONE);
  assign out_busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_fp_div_post.sv
// Randomized scoreboard bench for fp_div_post: stimulus pushes model results,
// a monitor pops and compares on each rising out_valid.
module tb_fp_div_post;
  import fp_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_start, in_sign, in_div_stall, in_guard, in_sticky, in_ack;
  logic [9:0]  in_exp;
  logic [2:0]  in_rm, in_special;
  logic [23:0] in_quotient;
  logic [31:0] out_result;
  logic [4:0]  out_fflags;
  logic        out_valid, out_busy;

  fp_div_post #(.EXP_W(10), .MANT_W(24)) dut (
    .in_Clk(clk), .in_Rst(rst), .in_start(in_start), .in_sign(in_sign),
    .in_exp(in_exp), .in_rm(in_rm), .in_special(in_special),
    .in_div_stall(in_div_stall), .in_quotient(in_quotient), .in_guard(in_guard),
    .in_sticky(in_sticky), .in_ack(in_ack), .out_result(out_result),
    .out_fflags(out_fflags), .out_valid(out_valid), .out_busy(out_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Model: value = keep + frac4/4 ulp, rounded by the mode's direction rule.
  function automatic void ref_norm(input bit sg, input int ex, input int rm, input int q,
                                   input bit g, input bit st,
                                   output logic [31:0] res, output logic [4:0] fl);
    int keep, e, frac4, mode;
    bit inexact, up, to_inf;
    if (q >= 'h800000) begin
      keep = q; e = ex; frac4 = (g ? 2 : 0) + (st ? 1 : 0);
    end else begin
      keep = q * 2 + int'(g); e = ex - 1; frac4 = st ? 1 : 0;
    end
    inexact = (frac4 != 0);
    mode = (rm > 4) ? 0 : rm;
    case (mode)
      0: up = (frac4 > 2) || (frac4 == 2 && (keep % 2) == 1);
      1: up = 1'b0;
      2: up = inexact && sg;
      3: up = inexact && !sg;
      default: up = (frac4 >= 2);
    endcase
    to_inf = (mode == 0) || (mode == 4) || (mode == 3 && !sg) || (mode == 2 && sg);
    keep = keep + int'(up);
    if (keep == (1 << 24)) begin
      keep = 1 << 23; e = e + 1;
    end
    if (e - int'(up && keep == (1 << 23) && e > 0 ? 0 : 0) <= 0 && ((q >= 'h800000) ? ex : ex - 1) <= 0) begin
      res = {sg, 31'b0}; fl = 5'b00011;
    end else if (e >= 255) begin
      res = (to_inf ? 32'h7F80_0000 : 32'h7F7F_FFFF) | {sg, 31'b0}; fl = 5'b00101;
    end else begin
      res = {sg, 8'(e), 23'(keep)}; fl = {4'b0, inexact};
    end
  endfunction

  function automatic void ref_spec(input int code, input bit sg,
                                   output logic [31:0] res, output logic [4:0] fl);
    res = 32'h7FC0_0000; fl = 5'b0;
    case (code)
      2: fl = 5'b10000;
      3: res = 32'h7F80_0000 | {sg, 31'b0};
      4: begin res = 32'h7F80_0000 | {sg, 31'b0}; fl = 5'b01000; end
      5: res = {sg, 31'b0};
      default: ;
    endcase
  endfunction

  // Monitor
  initial begin
    logic pv;
    exp_t e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !pv) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_valid: got result 0x%08h with empty scoreboard", out_result);
        end else begin
          e = sb.pop_front();
          check("result", out_result, e.res);
          check("fflags", 32'(out_fflags), 32'(e.flg));
          check("latency_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      pv = out_valid;
    end
  end

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL valid_timeout: got no out_valid, expected one within 20 cycles");
    end
  endtask

  task automatic finish_txn(input logic [31:0] r, input logic [4:0] f, input int hold);
    bit ok;
    wait_valid(ok);
    if (ok) begin
      for (int i = 0; i < hold; i++) begin
        if (i == 1) begin in_start = 1'b1; in_special = SP_DIVZERO; end
        @(negedge clk);
        in_start = 1'b0; in_special = SP_NONE;
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_result", out_result, r);
        check("hold_fflags", 32'(out_fflags), 32'(f));
      end
    end
    in_ack = 1'b1; in_start = 1'b1; in_special = SP_INF;
    @(negedge clk);
    in_ack = 1'b0; in_start = 1'b0; in_special = SP_NONE;
    check("ack_valid_low", 32'(out_valid), 32'd0);
    check("ack_busy_low", 32'(out_busy), 32'd0);
  endtask

  task automatic run_norm(input bit sg, input int ex, input int rm, input int q, input bit g,
                          input bit st, input int nstall, input int hold);
    logic [31:0] r;
    logic [4:0]  f;
    exp_t e;
    ref_norm(sg, ex, rm, q, g, st, r, f);
    @(negedge clk);
    in_start = 1'b1; in_sign = sg; in_exp = 10'(ex); in_rm = 3'(rm);
    in_special = SP_NONE; in_div_stall = 1'b0; in_quotient = 24'($urandom);
    @(negedge clk);
    in_start = 1'b0; in_sign = 1'($urandom); in_exp = 10'($urandom); in_rm = 3'($urandom);
    in_special = 3'($urandom); in_div_stall = 1'b1;
    repeat (nstall - 1) @(negedge clk);
    @(negedge clk);
    in_div_stall = 1'b0; in_quotient = 24'(q); in_guard = g; in_sticky = st;
    e.res = r; e.flg = f; e.cyc = cyc + 2;
    sb.push_back(e);
    @(negedge clk);
    in_quotient = 24'($urandom); in_guard = 1'($urandom); in_sticky = 1'($urandom);
    in_special = SP_NONE;
    finish_txn(r, f, hold);
  endtask

  task automatic run_spec(input bit sg, input int code, input int hold);
    logic [31:0] r;
    logic [4:0]  f;
    exp_t e;
    ref_spec(code, sg, r, f);
    @(negedge clk);
    in_start = 1'b1; in_sign = sg; in_exp = 10'($urandom); in_rm = 3'($urandom);
    in_special = 3'(code); in_div_stall = 1'b0;
    e.res = r; e.flg = f; e.cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    in_start = 1'b0; in_special = SP_NONE; in_sign = 1'($urandom);
    finish_txn(r, f, hold);
  endtask

  initial begin
    int q, code;
    rst = 1'b1; in_start = 0; in_sign = 0; in_exp = '0; in_rm = '0; in_special = '0;
    in_div_stall = 0; in_quotient = '0; in_guard = 0; in_sticky = 0; in_ack = 0;
    repeat (2) @(negedge clk);
    check("reset_result", out_result, 32'h0);
    check("reset_fflags", 32'(out_fflags), 32'h0);
    check("reset_valid", 32'(out_valid), 32'h0);
    check("reset_busy", 32'(out_busy), 32'h0);
    rst = 1'b0;

    run_norm(0, 128, 0, 'hC00000, 0, 0, 3, 0);
    run_norm(0, 126, 0, 'hFFFFFF, 1, 0, 2, 0);
    run_norm(0, 126, 1, 'hFFFFFF, 1, 0, 1, 0);
    run_norm(0, 128, 0, 'h400000, 0, 0, 2, 0);
    run_norm(0, 255, 0, 'h800000, 0, 0, 2, 0);
    run_norm(0, 255, 1, 'h800000, 0, 0, 2, 0);
    run_norm(1, 0, 0, 'h800000, 0, 0, 2, 0);
    run_norm(1, 254, 2, 'hFFFFFF, 0, 1, 1, 0);
    run_norm(1, 254, 3, 'hFFFFFF, 0, 1, 1, 0);
    run_spec(1, 4, 0);
    run_spec(0, 2, 0);
    run_spec(1, 5, 0);
    run_spec(0, 7, 0);
    run_norm(0, 130, 4, 'hA5A5A5, 1, 1, 2, 5);

    // Abort in WAIT: outputs clear before the next clock edge
    @(negedge clk);
    in_start = 1'b1; in_sign = 1'b1; in_exp = 10'd140; in_rm = RM_RNE; in_special = SP_NONE;
    @(negedge clk);
    in_start = 1'b0; in_div_stall = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_result", out_result, 32'h0);
    check("async_rst_fflags", 32'(out_fflags), 32'h0);
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_busy", 32'(out_busy), 32'h0);
    @(negedge clk);
    rst = 1'b0; in_div_stall = 1'b0;
    run_norm(0, 127, 0, 'h8CCCCD, 1, 0, 2, 1);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        q = int'($urandom & 32'hFF_FFFF);
        if (q < 'h800000 && $urandom_range(0, 3) != 0) q = q | 'h400000;
        run_norm(1'($urandom), int'($urandom_range(0, 280)) - 10, int'($urandom_range(0, 7)),
                 q, 1'($urandom), 1'($urandom), int'($urandom_range(1, 4)),
                 int'($urandom_range(0, 2)));
      end else begin
        code = int'($urandom_range(1, 7));
        run_spec(1'($urandom), code, int'($urandom_range(0, 2)));
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
